// File: rtl/io_seg_display_pkg.sv
// io_seg_pkg: types and constants shared across the io_seg_display slice.
//   state_t      : controller states (IDLE, CONV, UPD)
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : only segment g on, used for overflow
//   BIN_W/BCD_W  : width of the binary operand and of its BCD result
//   DEC_MAX      : largest value representable on six decimal digits
//   SEG_TABLE    : active-low {g,f,e,d,c,b,a} codes for digits 0..F
//   dd_step      : one double-dabble iteration on the {bcd, bin} register
package io_seg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      UPD  = 2'd2
   } state_t;

   localparam int BIN_W = 20;
   localparam int BCD_W = 24;
   localparam int SR_W  = BCD_W + BIN_W;

   localparam logic [BIN_W-1:0] DEC_MAX = 20'd999999;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Add 3 to every BCD nibble >= 5, then shift the whole register left.
   function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
      logic [SR_W-1:0] t;
      t = sr;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (t[BIN_W + 4*i +: 4] >= 4'd5)
            t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
      end
      return {t[SR_W-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/io_seg_display_if.sv
// io_seg_display_if: display register value in, six digit patterns and
// busy out.
//   display     : 32-bit register value (bit 31 = hex mode)
//   hex0..hex5  : active-low segment patterns {g,f,e,d,c,b,a}
//   busy        : conversion in progress
// master = register/CPU side, slave = the display block.
interface io_seg_display_if;

   logic [31:0] display;
   logic [6:0]  hex0;
   logic [6:0]  hex1;
   logic [6:0]  hex2;
   logic [6:0]  hex3;
   logic [6:0]  hex4;
   logic [6:0]  hex5;
   logic        busy;

   modport master (
      output display,
      input  hex0, hex1, hex2, hex3, hex4, hex5, busy
   );

   modport slave (
      input  display,
      output hex0, hex1, hex2, hex3, hex4, hex5, busy
   );

endinterface

// File: rtl/io_seg_display_seg7_decode.sv
// seg7_decode: combinational nibble to seven-segment pattern.
//   nib : 4-bit digit value 0..F
//   seg : active-low pattern {g,f,e,d,c,b,a}
module seg7_decode
   import io_seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/io_seg_display.sv
// io_seg_display: turns the memory-mapped display register into six
// active-low seven-segment digits (hex5 most significant).
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : slave side of io_seg_display_if (display in, hex0..hex5 and
//            busy out)
// A new value is picked up whenever it differs from the last captured one.
// Hex mode (display[31]=1) shows raw nibbles; decimal mode converts
// display[19:0] with a 20-step double-dabble and blanks leading zeros.
module io_seg_display
   import io_seg_pkg::*;
#(
   parameter int NDIG = 6
) (
   input  logic             clock,
   input  logic             resetn,
   io_seg_display_if.slave  bus
);

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       snapshot;
   logic              snap_valid;
   logic [SR_W-1:0]   sr;
   logic [4:0]        cnt;
   logic              ovf;
   logic              capture;
   logic              hex_mode;
   logic [6:0]        hex_q   [NDIG];
   logic [3:0]        nib     [NDIG];
   logic [6:0]        dec_seg [NDIG];
   logic [6:0]        out_seg [NDIG];
   logic [NDIG-1:0]   blank;

   assign capture  = (state == IDLE) && (!snap_valid || (bus.display != snapshot));
   assign hex_mode = snapshot[31];

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (capture) begin
               if (bus.display[31] || (bus.display[BIN_W-1:0] > DEC_MAX))
                  state_nxt = UPD;
               else
                  state_nxt = CONV;
            end
         end
         CONV: begin
            if (cnt == 5'd19)
               state_nxt = UPD;
         end
         UPD:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         snapshot   <= '0;
         snap_valid <= 1'b0;
         sr         <= '0;
         cnt        <= '0;
         ovf        <= 1'b0;
         for (int i = 0; i < NDIG; i++)
            hex_q[i] <= SEG_BLANK;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  snapshot   <= bus.display;
                  snap_valid <= 1'b1;
                  ovf        <= !bus.display[31] && (bus.display[BIN_W-1:0] > DEC_MAX);
                  sr         <= {{BCD_W{1'b0}}, bus.display[BIN_W-1:0]};
                  cnt        <= '0;
               end
            end
            CONV: begin
               sr  <= dd_step(sr);
               cnt <= cnt + 5'd1;
            end
            UPD: begin
               for (int i = 0; i < NDIG; i++)
                  hex_q[i] <= out_seg[i];
            end
            default: ;
         endcase
      end
   end

   // Digit source: raw snapshot nibbles in hex mode, BCD result otherwise.
   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      assign nib[g] = hex_mode ? snapshot[4*g +: 4] : sr[BIN_W + 4*g +: 4];
      seg7_decode u_dec (
         .nib (nib[g]),
         .seg (dec_seg[g])
      );
   end

   // A digit is blank when it and every more significant BCD digit are zero;
   // the units digit is never blanked so zero still reads "0".
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      blank    = '0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         zero_run = zero_run && (sr[BIN_W + 4*i +: 4] == 4'd0);
         blank[i] = zero_run && (i != 0);
      end
   end

   always_comb begin
      for (int i = 0; i < NDIG; i++) begin
         out_seg[i] = dec_seg[i];
         if (ovf)
            out_seg[i] = SEG_DASH;
         else if (!hex_mode && blank[i])
            out_seg[i] = SEG_BLANK;
      end
   end

   assign bus.hex0 = hex_q[0];
   assign bus.hex1 = hex_q[1];
   assign bus.hex2 = hex_q[2];
   assign bus.hex3 = hex_q[3];
   assign bus.hex4 = hex_q[4];
   assign bus.hex5 = hex_q[5];
   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_io_seg_display.sv
// tb_io_seg_display: scoreboard bench for io_seg_display. Stimulus pushes the
// expected digits and busy length for every value that will be captured; a
// negedge monitor pops and compares each time busy falls, and checks that
// the outputs never move at any other time.
module tb_io_seg_display;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   io_seg_display_if bus ();

   io_seg_display #(.NDIG(6)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct {
      logic [41:0] hex;
      int          dur;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   localparam logic [41:0] ALL_BLANK = {6{7'b1111111}};
   localparam logic [41:0] ALL_DASH  = {6{7'b0111111}};

   logic [31:0] snap_m;
   bit          snap_v_m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: what the six digits should read for a register value.
   function automatic exp_t model(input logic [31:0] v);
      exp_t        e;
      int unsigned n;
      int unsigned d [6];
      int          top;
      e.hex = '0;
      if (v[31]) begin
         for (int i = 0; i < 6; i++) e.hex[7*i +: 7] = seg_tab[v[4*i +: 4]];
         e.dur = 1;
      end else begin
         n = int'(v[19:0]);
         if (n > 999999) begin
            e.hex = ALL_DASH;
            e.dur = 1;
         end else begin
            top = 0;
            for (int i = 0; i < 6; i++) begin
               d[i] = n % 10;
               n    = n / 10;
               if (d[i] != 0) top = i;
            end
            for (int i = 0; i < 6; i++)
               e.hex[7*i +: 7] = (i > top) ? 7'b1111111 : seg_tab[d[i]];
            e.dur = 21;
         end
      end
      return e;
   endfunction

   function automatic logic [41:0] cur_hex();
      return {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
   endfunction

   task automatic expect_capture(input logic [31:0] v);
      if (!snap_v_m || v != snap_m) begin
         q.push_back(model(v));
         snap_m   = v;
         snap_v_m = 1'b1;
      end
   endtask

   task automatic issue(input logic [31:0] v);
      @(posedge clock);
      #1 bus.display = v;
      expect_capture(v);
   endtask

   task automatic wait_done();
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (q.size() == 0 && !bus.busy) return;
      end
      total++;
      bad++;
      $display("FAIL wait_done: timeout, %0d results outstanding", q.size());
      q.delete();
   endtask

   // Monitor
   bit          prev_busy = 1'b0;
   int          run       = 0;
   logic [41:0] last_hex  = ALL_BLANK;

   always @(negedge clock) begin
      if (!resetn) begin
         q.delete();
         prev_busy = 1'b0;
         run       = 0;
         last_hex  = ALL_BLANK;
      end else begin
         if (bus.busy) run++;
         if (prev_busy && !bus.busy) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_update: got %h with no pending value", cur_hex());
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("digits", 64'(cur_hex()), 64'(e.hex));
               chk("busy_len", 64'(run), 64'(e.dur));
            end
            run      = 0;
            last_hex = cur_hex();
         end else begin
            chk("hold", 64'(cur_hex()), 64'(last_hex));
         end
         prev_busy = bus.busy;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      resetn      = 1'b0;
      bus.display = 32'd123456;
      snap_v_m    = 1'b0;
      snap_m      = '0;
      @(posedge clock);
      #1;
      chk("reset_digits", 64'(cur_hex()), 64'(ALL_BLANK));
      chk("reset_busy", 64'(bus.busy), 64'd0);
      @(posedge clock);
      #1 resetn = 1'b1;
      expect_capture(32'd123456);
      wait_done();
      chk("dec_123456", 64'(cur_hex()),
          64'({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010}));

      issue(32'd7);
      wait_done();
      chk("dec_7", 64'(cur_hex()), 64'({{5{7'b1111111}}, 7'b1111000}));
      issue(32'd0);
      wait_done();
      chk("dec_0", 64'(cur_hex()), 64'({{5{7'b1111111}}, 7'b1000000}));

      issue(32'd1000000);
      wait_done();
      chk("overflow", 64'(cur_hex()), 64'(ALL_DASH));

      issue(32'h8012_ABCD);
      wait_done();
      chk("hex_mode", 64'(cur_hex()),
          64'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}));
      issue(32'h8012_ABCD);
      repeat (30) @(negedge clock);
      wait_done();

      // Change arriving mid-conversion is picked up after the update.
      issue(32'd42);
      @(posedge clock);
      repeat (5) @(posedge clock);
      #1 bus.display = 32'd99;
      expect_capture(32'd99);
      wait_done();
      chk("dec_99", 64'(cur_hex()), 64'({{4{7'b1111111}}, 7'b0010000, 7'b0010000}));

      // Reset in the middle of a decimal conversion.
      issue(32'd654321);
      @(posedge clock);
      repeat (10) @(posedge clock);
      #1 resetn = 1'b0;
      #1;
      chk("midreset_digits", 64'(cur_hex()), 64'(ALL_BLANK));
      chk("midreset_busy", 64'(bus.busy), 64'd0);
      snap_v_m = 1'b0;
      @(posedge clock);
      #1 resetn = 1'b1;
      expect_capture(32'd654321);
      wait_done();
      chk("recapture", 64'(cur_hex()),
          64'({7'b0000010, 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}));

      for (int k = 0; k < 24; k++) begin
         v = $urandom();
         case ($urandom_range(0, 3))
            0: v[31] = 1'b1;
            1: begin v[31] = 1'b0; v[19:0] = 20'($urandom_range(0, 999999)); end
            2: begin v[31] = 1'b0; v[19:0] = 20'($urandom_range(1000000, 1048575)); end
            default: v = snap_m;
         endcase
         issue(v);
         wait_done();
      end

      repeat (5) @(negedge clock);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_seg_display.md
Name: io_seg_display

Overview:
- Device-side consumer of the memory-mapped display register. The CPU writes that register at address 0x8000_000C, and its 32-bit value feeds this block.
- Converts the register value into six active-low seven-segment digit patterns, HEX5 (most significant) to HEX0.
- Decimal mode uses a sequential double-dabble binary-to-BCD converter with leading-zero blanking. Hexadecimal mode shows raw nibbles.
- Runs in the CPU clock domain. It needs no bus handshake and detects updates by comparing values.

Parameters:
- NDIG, 6, number of digits driven. Fixed at 6; only 6 is supported.
- BIN_W, 20, width of the decimal operand taken from display[19:0].
- DEC_MAX, 999999, largest decimal value shown before overflow.

Ports:
- clock  in  1  system clock. All state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- display  in  32  display register value from the memory controller.
  - Bit 31: 1 selects hex mode, 0 selects decimal mode.
- hex0 .. hex5  out  7 each  segment patterns, active-low, bit order {g,f,e,d,c,b,a}.
- busy  out  1  high while a conversion is in progress (state != IDLE).

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, snapshot=0, snap_valid=0.
  - hex0..hex5 = 7'b1111111 (blank), busy=0.
- Change detection:
  - In IDLE, a capture occurs at edge E0 when (snap_valid==0) or (display != snapshot).
  - On capture: snapshot<=display, snap_valid<=1.
  - The full 32-bit word is compared, so writes of an identical value cause no activity.
- States: IDLE, CONV, UPD.
  - IDLE, capture with display[31]=1 -> UPD.
  - IDLE, capture with display[31]=0 and display[19:0] > DEC_MAX -> UPD, with the overflow flag set.
  - IDLE, capture with display[31]=0 and display[19:0] <= DEC_MAX -> CONV.
    - On entry: shift register {bcd[23:0], bin[19:0]} = {24'b0, display[19:0]}, cnt=0.
  - CONV: one double-dabble iteration per edge.
    - First add 3 to every BCD nibble that is >= 5.
    - Then shift the 44-bit register left by 1.
    - cnt increments. When cnt==19 at the edge, go to UPD.
  - UPD: hex0..hex5 are registered at this edge, then return to IDLE.
- Latency from capture edge E0 to outputs changing:
  - hex mode and overflow: E0+1.
  - decimal: E0+21 (20 CONV edges E0+1..E0+20, UPD at E0+21).
  - busy is high from E0 through E0+21 (decimal) or E0+1 (hex).
- Hex mode: hexN = seg(snapshot[4N+3:4N]). Bits 30:24 are ignored. No blanking.
- Decimal mode:
  - hexN = seg(bcd nibble N).
  - Leading-zero blanking: hexN (N>=1) is blank if nibble N and all higher nibbles are 0.
  - hex0 always shows its digit, so value 0 shows "0".
  - Bits 30:20 are ignored for the value but still take part in change detection.
- Overflow: all six digits = dash 7'b0111111.
- Change during CONV/UPD is ignored. It is re-detected in IDLE on the edge after UPD, because display differs from snapshot.
- Reset mid-conversion: immediate return to the reset values. The first post-reset edge with resetn=1 captures display, because snap_valid=0.
- Outputs hold their last values in IDLE. There are no glitches between updates, because outputs change only in UPD.
- Segment codes (active-low {g..a}), digits 0..F:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

Decomposition:
- Package io_seg_pkg:
  - state enum (IDLE, CONV, UPD);
  - SEG_BLANK=7'b1111111 and SEG_DASH=7'b0111111;
  - BIN_W and DEC_MAX constants;
  - the 16-entry digit code table.
- Sub-module seg7_decode: combinational 4-bit nibble -> 7-bit active-low pattern. Instantiated six times.

Test Plan:
- Reset, then display=32'd123456 held:
  - capture at first edge;
  - busy high 22 edges;
  - at E0+21, hex5..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010.
- display=32'd7:
  - hex0=1111000, hex1..hex5=1111111 at E0+21.
  - Then display=32'd0 gives hex0=1000000 and the rest blank.
- display=32'd1000000 (above DEC_MAX): all digits 0111111 at E0+1; busy high only for one cycle.
- display=32'h8012_ABCD:
  - at E0+1, hex5..hex0 = 1111001, 0100100, 0001000, 0000011, 1000110, 0100001;
  - rewriting the same value causes no busy pulse.
- Decimal 42 captured, then display changed to 32'd99 at E0+5:
  - hex shows "42" at E0+21;
  - new capture at E0+22;
  - "99" (0010000, 0010000) shown at E0+43.
- resetn pulsed low at E0+10 of a decimal conversion:
  - outputs go blank and busy=0 immediately;
  - after release, the held display value is recaptured and converted correctly.
